// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter slice.
// Holds the bus_mode encodings, access width encodings, the arbiter FSM state
// type and the default SRAM window used by the arbiter and its range decoder.
package data_bus_arbiter_pkg;

  // Encoding driven on bus_mode.
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10
  } bus_mode_e;

  // Access width encodings carried on *_width and bus_reqw.
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  // Default SRAM byte-address window (inclusive on both ends).
  localparam logic [31:0] SRAM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] SRAM_LAST_DEFAULT = 32'h0000_3FFF;

endpackage

// File: rtl/data_bus_arbiter_addr_range_check.sv
// Address range decoder for the data bus arbiter.
// Flags whether a byte address lies inside the inclusive window
// [BASE_ADDR, LAST_ADDR].
// Ports:
//   addr     - byte address to classify
//   in_range - 1 when BASE_ADDR <= addr <= LAST_ADDR
module addr_range_check
  import data_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_DEFAULT,
  parameter logic [31:0] LAST_ADDR = SRAM_LAST_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  // Inclusive window compare on both ends.
  always_comb begin
    in_range = 1'b0;
    if ((addr >= BASE_ADDR) && (addr <= LAST_ADDR)) begin
      in_range = 1'b1;
    end else begin
      in_range = 1'b0;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter between a core and a DMA requester sharing one SRAM bus.
// Each access runs IDLE -> ADDR (-> DATA for in-range reads) -> IDLE.
// Out-of-range accesses never reach the bus and complete in ADDR with err.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   core_*/dma_* inputs       - req (held until ready), we, addr, wdata,
//                               width, signed
//   core_*/dma_* outputs      - ready pulse, rdata (reads only), err
//   bus_addr/mode/reqw/reqs   - bus command, driven only in ADDR
//   bus_wdata/bus_wdrive      - write data and its tristate enable
//   bus_rdata                 - read data returned in DATA
//   stall_lw                  - core pipeline stall while core waits
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = SRAM_BASE_DEFAULT,
  parameter logic [31:0] SRAM_LAST_ADDR = SRAM_LAST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_width,
  input  logic        core_signed,
  output logic        core_ready,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_width,
  input  logic        dma_signed,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_mode,
  output logic [1:0]  bus_reqw,
  output logic        bus_reqs,
  output logic [31:0] bus_wdata,
  output logic        bus_wdrive,
  input  logic [31:0] bus_rdata,
  output logic        stall_lw
);

  state_e      state_q, state_d;
  logic        grant_dma_q, grant_dma_d;
  logic        last_dma_q, last_dma_d;

  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [1:0]  sel_width_s;
  logic        sel_signed_s;
  logic        in_range_s;
  logic        done_s;
  logic        err_s;
  logic [31:0] rdata_s;

  // Select the granted requester's live request fields.
  always_comb begin
    sel_we_s     = 1'b0;
    sel_addr_s   = 32'h0000_0000;
    sel_wdata_s  = 32'h0000_0000;
    sel_width_s  = 2'b00;
    sel_signed_s = 1'b0;
    if (grant_dma_q) begin
      sel_we_s     = dma_we;
      sel_addr_s   = dma_addr;
      sel_wdata_s  = dma_wdata;
      sel_width_s  = dma_width;
      sel_signed_s = dma_signed;
    end else begin
      sel_we_s     = core_we;
      sel_addr_s   = core_addr;
      sel_wdata_s  = core_wdata;
      sel_width_s  = core_width;
      sel_signed_s = core_signed;
    end
  end

  addr_range_check #(
    .BASE_ADDR (SRAM_BASE_ADDR),
    .LAST_ADDR (SRAM_LAST_ADDR)
  ) u_addr_range_check (
    .addr     (sel_addr_s),
    .in_range (in_range_s)
  );

  // State and grant registers; last_dma resets to 1 so the core wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_dma_q <= 1'b0;
      last_dma_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_dma_q <= grant_dma_d;
      last_dma_q  <= last_dma_d;
    end
  end

  // Next-state, arbitration and bus command decode.
  always_comb begin
    state_d     = state_q;
    grant_dma_d = grant_dma_q;
    last_dma_d  = last_dma_q;
    done_s      = 1'b0;
    err_s       = 1'b0;
    rdata_s     = 32'h0000_0000;
    bus_mode    = BUS_IDLE;
    bus_addr    = 32'h0000_0000;
    bus_wdata   = 32'h0000_0000;
    bus_reqw    = 2'b00;
    bus_reqs    = 1'b0;
    bus_wdrive  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_req || dma_req) begin
          // On a tie the side that was not served last goes next.
          if (core_req && dma_req) begin
            grant_dma_d = ~last_dma_q;
          end else begin
            grant_dma_d = dma_req;
          end
          last_dma_d = grant_dma_d;
          state_d    = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!in_range_s) begin
          // Decode error: keep the bus idle and complete immediately.
          done_s  = 1'b1;
          err_s   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bus_mode   = sel_we_s ? BUS_WRITE : BUS_READ;
          bus_addr   = sel_addr_s;
          bus_wdata  = sel_wdata_s;
          bus_reqw   = sel_width_s;
          bus_reqs   = sel_signed_s;
          bus_wdrive = sel_we_s;
          if (sel_we_s) begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        done_s  = 1'b1;
        rdata_s = bus_rdata;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Steer completion to the granted requester only; the other side sees zeros.
  always_comb begin
    core_ready = 1'b0;
    core_err   = 1'b0;
    core_rdata = 32'h0000_0000;
    dma_ready  = 1'b0;
    dma_err    = 1'b0;
    dma_rdata  = 32'h0000_0000;
    if (grant_dma_q) begin
      dma_ready = done_s;
      dma_err   = err_s;
      dma_rdata = rdata_s;
    end else begin
      core_ready = done_s;
      core_err   = err_s;
      core_rdata = rdata_s;
    end
  end

  assign stall_lw = core_req & ~core_ready;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: rounds of core/DMA requests push
// expected completions (owner, err, rdata, bus cycle, ready cycle) into a
// queue; a negedge monitor compares the DUT against the queue head.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_signed;
  logic [31:0] core_addr, core_wdata;
  logic [1:0]  core_width;
  logic        dma_req, dma_we, dma_signed;
  logic [31:0] dma_addr, dma_wdata;
  logic [1:0]  dma_width;
  logic        core_ready, core_err, dma_ready, dma_err;
  logic [31:0] core_rdata, dma_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_mode, bus_reqw;
  logic        bus_reqs, bus_wdrive, stall_lw;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    bit          sgn;
  } txn_t;

  typedef struct {
    bit          who;   // 1 = dma
    txn_t        t;
    bit          err;
    logic [31:0] rdata;
    int          gcyc;  // cycle the bus command is visible
    int          dcyc;  // cycle ready pulses
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   last_m;        // reference: 1 when dma was served last

  data_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_width(core_width), .core_signed(core_signed),
    .core_ready(core_ready), .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_width(dma_width), .dma_signed(dma_signed),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_reqw(bus_reqw),
    .bus_reqs(bus_reqs), .bus_wdata(bus_wdata), .bus_wdrive(bus_wdrive),
    .bus_rdata(bus_rdata), .stall_lw(stall_lw)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave content: fixed word at 0x3800, hashed pattern elsewhere.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h0000_3800) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit in_sram(input logic [31:0] a);
    return (a >= 32'h0000_3000) && (a <= 32'h0000_3FFF);
  endfunction

  function automatic txn_t mk(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] w, input bit s);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.width = w; t.sgn = s;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   sel;
    sel     = int'($urandom_range(0, 9));
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.width = 2'($urandom_range(0, 2));
    t.sgn   = 1'($urandom_range(0, 1));
    case (sel)
      0:       t.addr = 32'h0000_3000;
      1:       t.addr = 32'h0000_3FFF;
      2:       t.addr = 32'h0000_2FFF;
      3:       t.addr = 32'h0000_4000;
      4:       t.addr = $urandom;
      default: t.addr = 32'h0000_3000 + 32'($urandom_range(0, 32'h0FFF));
    endcase
    return t;
  endfunction

  // Monitor: bus command, completion and stall checks against the queue head.
  initial forever begin
    logic [1:0]  em;
    logic [31:0] ea, ew;
    logic [1:0]  eqw;
    logic        eqs;
    exp_t        e;
    @(negedge clk);
    if (!reset) begin
      em = 2'b00; ea = 32'h0; ew = 32'h0; eqw = 2'b00; eqs = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].gcyc == cyc && !sb_q[0].err) begin
        em  = sb_q[0].t.we ? 2'b10 : 2'b01;
        ea  = sb_q[0].t.addr;
        ew  = sb_q[0].t.wdata;
        eqw = sb_q[0].t.width;
        eqs = sb_q[0].t.sgn;
      end
      check("bus_mode",   32'(bus_mode),   32'(em));
      check("bus_addr",   bus_addr,        ea);
      check("bus_wdata",  bus_wdata,       ew);
      check("bus_reqw",   32'(bus_reqw),   32'(eqw));
      check("bus_reqs",   32'(bus_reqs),   32'(eqs));
      check("bus_wdrive", 32'(bus_wdrive), 32'(em == 2'b10));
      check("both_ready", 32'(core_ready & dma_ready), 32'h0);
      if (core_ready || dma_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", {30'b0, core_ready, dma_ready}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("ready_owner", 32'(dma_ready), 32'(e.who));
          check("ready_err",   32'(dma_ready ? dma_err : core_err), 32'(e.err));
          check("ready_rdata", dma_ready ? dma_rdata : core_rdata, e.rdata);
          check("ready_cycle", 32'(cyc), 32'(e.dcyc));
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].dcyc) begin
        e = sb_q.pop_front();
        check("missing_ready", {30'b0, core_ready, dma_ready}, e.who ? 32'h1 : 32'h2);
      end
      if (!core_ready) begin
        check("core_idle_outs", {core_rdata[30:0], core_err}, 32'h0);
      end
      if (!dma_ready) begin
        check("dma_idle_outs", {dma_rdata[30:0], dma_err}, 32'h0);
      end
      check("stall_lw", 32'(stall_lw), 32'(core_req & ~core_ready));
    end
    // Slave: present data for the address seen during a read command.
    if (bus_mode == 2'b01) bus_rdata = slave_data(bus_addr);
    else                   bus_rdata = $urandom;
  end

  // Issue one round starting in the current (idle) cycle; the reference
  // orders the grants and predicts cycles from the access-type latencies.
  task automatic run_round(input bit use_c, input bit use_d, input txn_t tc, input txn_t td);
    bit   first_dma, c_done, d_done;
    int   g;
    exp_t e;
    first_dma = (use_c && use_d) ? ~last_m : use_d;
    g = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || (use_c && use_d)) begin
        e.who   = (k == 0) ? first_dma : ~first_dma;
        e.t     = e.who ? td : tc;
        e.err   = !in_sram(e.t.addr);
        e.rdata = (!e.err && !e.t.we) ? slave_data(e.t.addr) : 32'h0;
        e.gcyc  = g;
        e.dcyc  = g + ((!e.err && !e.t.we) ? 1 : 0);
        sb_q.push_back(e);
        last_m  = e.who;
        g       = e.dcyc + 2;
      end
    end
    core_req = use_c;
    core_we = tc.we; core_addr = tc.addr; core_wdata = tc.wdata;
    core_width = tc.width; core_signed = tc.sgn;
    dma_req = use_d;
    dma_we = td.we; dma_addr = td.addr; dma_wdata = td.wdata;
    dma_width = td.width; dma_signed = td.sgn;
    c_done = !use_c;
    d_done = !use_d;
    for (int n = 0; n < 16 && !(c_done && d_done); n++) begin
      @(negedge clk);
      if (core_ready) c_done = 1'b1;
      if (dma_ready)  d_done = 1'b1;
      @(posedge clk); #1;
      if (c_done) core_req = 1'b0;
      if (d_done) dma_req = 1'b0;
    end
    if (!(c_done && d_done)) begin
      check("round_timeout", {30'b0, c_done, d_done}, 32'h3);
      sb_q.delete();
      core_req = 1'b0;
      dma_req  = 1'b0;
    end
  endtask

  initial begin
    txn_t nil, a, b;
    bit   uc, ud;
    nil = mk(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    core_width = 2'b00; core_signed = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    dma_width = 2'b00; dma_signed = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_ready", 32'(core_ready), 32'h0);
    check("rst_dma_ready",  32'(dma_ready),  32'h0);
    check("rst_errs",       {30'b0, core_err, dma_err}, 32'h0);
    check("rst_rdata",      core_rdata | dma_rdata, 32'h0);
    check("rst_bus_mode",   32'(bus_mode),   32'h0);
    check("rst_bus_wdrive", 32'(bus_wdrive), 32'h0);
    reset  = 1'b0;
    last_m = 1'b1;

    // Core word write, core word read returning 0x12345678.
    run_round(1'b1, 1'b0, mk(1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 2'b10, 1'b0), nil);
    run_round(1'b1, 1'b0, mk(1'b0, 32'h0000_3800, 32'h0, 2'b10, 1'b0), nil);
    // Repeated ties alternate between the two requesters.
    for (int i = 0; i < 3; i++) begin
      run_round(1'b1, 1'b1, mk(1'b1, 32'h0000_3010 + 32'(i), $urandom, 2'b10, 1'b0),
                            mk(i == 1, 32'h0000_3020 + 32'(i), $urandom, 2'b01, 1'b1));
    end
    // DMA decode errors just outside the window, and reads at its ends.
    run_round(1'b0, 1'b1, nil, mk(1'b0, 32'h0000_4000, 32'h0, 2'b10, 1'b0));
    run_round(1'b0, 1'b1, nil, mk(1'b0, 32'h0000_2FFF, 32'h0, 2'b10, 1'b0));
    run_round(1'b1, 1'b1, mk(1'b0, 32'h0000_3000, 32'h0, 2'b00, 1'b1),
                          mk(1'b0, 32'h0000_3FFF, 32'h0, 2'b00, 1'b0));

    // Reset during ADDR of a core read aborts it and idles the bus at once.
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_3800; core_width = 2'b10;
    @(posedge clk); #1;
    check("pre_rst_bus_mode", 32'(bus_mode), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_mode",   32'(bus_mode),   32'h0);
    check("mid_rst_bus_wdrive", 32'(bus_wdrive), 32'h0);
    check("mid_rst_core_ready", 32'(core_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_core_ready", 32'(core_ready), 32'h0);
    reset    = 1'b0;
    core_req = 1'b0;
    last_m   = 1'b1;
    run_round(1'b1, 1'b1, mk(1'b1, 32'h0000_3100, 32'h0BAD_F00D, 2'b10, 1'b0),
                          mk(1'b1, 32'h0000_3200, 32'h0000_1111, 2'b10, 1'b0));

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      uc = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!uc && !ud) uc = 1'b1;
      a = rand_txn();
      b = rand_txn();
      run_round(uc, ud, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
